// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplication buffer: RV32 opcodes, the NOP
// pattern, the instruction field layout and the duplicability test.
package qed_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned REG_W = 5;
   localparam int unsigned RV_W  = 32;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LW     = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_SW     = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_B      = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_J      = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

   localparam logic [RV_W-1:0] QED_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      REPLAY = 2'd2,
      DRAIN  = 2'd3
   } qed_state_e;

   // R-type field layout; other formats reuse the same bit positions
   typedef struct packed {
      logic [6:0]       funct7;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rs1;
      logic [2:0]       funct3;
      logic [REG_W-1:0] rd;
      logic [OPC_W-1:0] opcode;
   } rv_instr_t;

   // Control flow and system instructions are never duplicated
   function automatic logic is_duplicable(input logic [OPC_W-1:0] opcode);
      logic dup;
      case (opcode)
         OP_R, OP_I, OP_LW, OP_SW, OP_LUI, OP_AUIPC: dup = 1'b1;
         OP_B, OP_J, OP_JALR, OP_SYSTEM:             dup = 1'b0;
         default:                                    dup = 1'b0;
      endcase
      return dup;
   endfunction

endpackage

// File: rtl/qed_reg_remap.sv
// Combinational register remapper for duplicated instructions: every register
// field the format actually uses is moved into the shadow register bank.
module qed_reg_remap #(
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned REG_OFFSET = 16
) (
   input  logic [INSTR_W-1:0] instr_i,
   output logic [INSTR_W-1:0] instr_o
);
   import qed_pkg::*;

   rv_instr_t in_f;
   rv_instr_t out_f;

   // x0 and registers already in the shadow bank stay put
   function automatic logic [REG_W-1:0] remap_reg(input logic [REG_W-1:0] r);
      logic [REG_W-1:0] res;
      res = r;
      if ((r != '0) && (32'(r) < REG_OFFSET)) begin
         res = REG_W'(32'(r) + REG_OFFSET);
      end
      return res;
   endfunction

   always_comb begin
      in_f  = rv_instr_t'(instr_i[RV_W-1:0]);
      out_f = in_f;
      case (in_f.opcode)
         OP_R: begin
            out_f.rd  = remap_reg(in_f.rd);
            out_f.rs1 = remap_reg(in_f.rs1);
            out_f.rs2 = remap_reg(in_f.rs2);
         end
         OP_I, OP_LW: begin
            out_f.rd  = remap_reg(in_f.rd);
            out_f.rs1 = remap_reg(in_f.rs1);
         end
         OP_SW: begin
            out_f.rs1 = remap_reg(in_f.rs1);
            out_f.rs2 = remap_reg(in_f.rs2);
         end
         OP_LUI, OP_AUIPC: begin
            out_f.rd = remap_reg(in_f.rd);
         end
         default: ;
      endcase
      instr_o             = instr_i;
      instr_o[RV_W-1:0]   = out_f;
   end

endmodule

// File: rtl/qed_dup_buffer.sv
// QED duplication buffer between IFU and decode: records duplicable originals
// into a FIFO, then replays them as register-remapped duplicates.
module qed_dup_buffer #(
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned REG_OFFSET = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic                       exec_dup,
   input  logic                       stall_IF,
   input  logic                       ifu_vld,
   input  logic [INSTR_W-1:0]         ifu_qed_instruction,
   output logic [INSTR_W-1:0]         qed_ifu_instruction,
   output logic                       vld_out,
   output logic                       qed_full,
   output logic                       qed_empty,
   output logic [$clog2(DEPTH+1)-1:0] qed_count,
   output logic                       qed_ovf,
   output logic                       qed_stall_req
);
   import qed_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   qed_state_e         state_q, state_d;
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               full_q, empty_q, stall_req_q;
   logic [INSTR_W-1:0] out_q, out_d;
   logic               vld_q, vld_d;

   logic               fifo_full_c, fifo_empty_c, dup_c;
   logic               push_c, drop_c, pop_c, flush_c, replay_c;
   logic [INSTR_W-1:0] head_dup_c;

   assign fifo_full_c  = (count_q == CNT_W'(DEPTH));
   assign fifo_empty_c = (count_q == '0);
   assign dup_c        = is_duplicable(ifu_qed_instruction[OPC_W-1:0]);

   qed_reg_remap #(
      .INSTR_W    (INSTR_W),
      .REG_OFFSET (REG_OFFSET)
   ) u_remap (
      .instr_i (mem_q[rd_ptr_q]),
      .instr_o (head_dup_c)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next state; dropping ena during replay drains before going idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (ena && !exec_dup) state_d = RECORD;
         RECORD: begin
            if (!ena)          state_d = IDLE;
            else if (exec_dup) state_d = REPLAY;
         end
         REPLAY: if (!ena || !exec_dup) state_d = DRAIN;
         DRAIN:  if (fifo_empty_c) state_d = ena ? RECORD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      push_c   = 1'b0;
      drop_c   = 1'b0;
      pop_c    = 1'b0;
      flush_c  = 1'b0;
      replay_c = 1'b0;
      case (state_q)
         RECORD: begin
            flush_c = !ena;
            push_c  = ena && ifu_vld && !stall_IF && dup_c && !fifo_full_c;
            drop_c  = ena && ifu_vld && !stall_IF && dup_c &&  fifo_full_c;
         end
         REPLAY, DRAIN: begin
            replay_c = 1'b1;
            pop_c    = !stall_IF && !fifo_empty_c;
         end
         default: ;
      endcase
   end

   // FIFO bookkeeping and output stage next values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop_c;
      out_d    = out_q;
      vld_d    = vld_q;
      if (flush_c) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d  = count_q + CNT_W'(1);
      end else if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d  = count_q - CNT_W'(1);
      end
      if (!stall_IF) begin
         if (replay_c) begin
            out_d = fifo_empty_c ? INSTR_W'(QED_NOP) : head_dup_c;
            vld_d = !fifo_empty_c;
         end else begin
            out_d = ifu_qed_instruction;
            vld_d = ifu_vld;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         stall_req_q <= 1'b0;
         out_q       <= INSTR_W'(QED_NOP);
         vld_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         full_q      <= (count_d == CNT_W'(DEPTH));
         empty_q     <= (count_d == '0);
         stall_req_q <= (state_d == RECORD) && (count_d == CNT_W'(DEPTH));
         out_q       <= out_d;
         vld_q       <= vld_d;
      end
   end

   // Storage holds no control state, so it needs no reset
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= ifu_qed_instruction;
   end

   assign qed_ifu_instruction = out_q;
   assign vld_out             = vld_q;
   assign qed_full            = full_q;
   assign qed_empty           = empty_q;
   assign qed_count           = count_q;
   assign qed_ovf             = ovf_q;
   assign qed_stall_req       = stall_req_q;

endmodule
